// File: rtl/dpram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dpram_arb_pkg
// Purpose  : Shared types for the two-client dpram port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package dpram_arb_pkg;

    typedef logic owner_t;

    localparam owner_t c_OWNER0 = 1'b0;
    localparam owner_t c_OWNER1 = 1'b1;

    typedef enum logic [0:0] {
        ROUND_ROBIN = 1'b0,
        LOCKED      = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic   valid;
        owner_t owner;
    } ret_stage_t;

endpackage
`default_nettype wire

// File: rtl/dpram_port_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : dpram_port_arb_if
// Purpose  : Client-side request/grant/return bus of the dpram port arbiter.
//            Lock signals exist only when DPRAM_ARB_LOCK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface dpram_port_arb_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16
);
    logic                  req0, req1;
    logic                  we0, we1;
    logic [ADDR_WIDTH-1:0] addr0, addr1;
    logic [DATA_WIDTH-1:0] wdata0, wdata1;
    logic                  gnt0, gnt1;
    logic                  rvalid0, rvalid1;
    logic [DATA_WIDTH-1:0] rdata0, rdata1;
`ifdef DPRAM_ARB_LOCK_EN
    logic                  lock0, lock1;

    modport master (
        output req0, we0, addr0, wdata0, lock0,
        output req1, we1, addr1, wdata1, lock1,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1
    );
    modport slave (
        input  req0, we0, addr0, wdata0, lock0,
        input  req1, we1, addr1, wdata1, lock1,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1
    );
`else
    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1
    );
    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1
    );
`endif
endinterface
`default_nettype wire

// File: rtl/dpram_arb_rr.sv
`default_nettype none
// ============================================================================
// Module   : dpram_arb_rr
// Purpose  : Two-way round-robin grant with the most-recent-winner pointer.
// Revision : 1.0 - initial release
// ============================================================================
module dpram_arb_rr
    import dpram_arb_pkg::*;
(
    input  wire  clk,
    input  wire  rst_n,
    input  wire  i_req0,
    input  wire  i_req1,
    output logic o_gnt0,
    output logic o_gnt1
);

    owner_t r_last;

    // On contention the requester that did not win last time goes first.
    always_comb begin
        o_gnt0 = i_req0 & (~i_req1 | (r_last == c_OWNER1));
        o_gnt1 = i_req1 & (~i_req0 | (r_last == c_OWNER0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= c_OWNER1;
        end else if (o_gnt0) begin
            r_last <= c_OWNER0;
        end else if (o_gnt1) begin
            r_last <= c_OWNER1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dpram_port_arb.sv
`default_nettype none
// ============================================================================
// Module   : dpram_port_arb
// Purpose  : Shares one dpram port between two clients: round-robin grant,
//            registered issue stage and owner-tagged read return.
//            Optional burst lock enabled by DPRAM_ARB_LOCK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module dpram_port_arb
    import dpram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16,
    parameter int RD_LATENCY = 1
) (
    input  wire                   clk,
    input  wire                   rst_n,
    dpram_port_arb_if.slave       bus,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic                  mem_wr_en,
    input  wire  [DATA_WIDTH-1:0] mem_rd_data
);

    logic                  w_arb_req0, w_arb_req1;
    logic                  w_rr_gnt0, w_rr_gnt1;
    logic                  w_gnt0, w_gnt1, w_xfer, w_we;
    owner_t                w_owner;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_wdata;
    ret_stage_t            w_ret_out;

    ret_stage_t [RD_LATENCY:0] r_ret;
    logic                      r_rvalid0, r_rvalid1;
    logic [DATA_WIDTH-1:0]     r_rdata0, r_rdata1;

`ifdef DPRAM_ARB_LOCK_EN
    arb_state_t r_state, w_state_nxt;
    owner_t     r_lock_owner, w_lock_owner_nxt;
    logic       w_owner_lock;

    // While locked, the non-owner is hidden from the round-robin core.
    assign w_arb_req0 = bus.req0 & ~((r_state == LOCKED) && (r_lock_owner == c_OWNER1));
    assign w_arb_req1 = bus.req1 & ~((r_state == LOCKED) && (r_lock_owner == c_OWNER0));
    assign w_owner_lock = (w_owner == c_OWNER1) ? bus.lock1 : bus.lock0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ROUND_ROBIN;
            r_lock_owner <= c_OWNER0;
        end else begin
            r_state      <= w_state_nxt;
            r_lock_owner <= w_lock_owner_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_lock_owner_nxt = r_lock_owner;
        if (w_xfer) begin
            if (w_owner_lock) begin
                w_state_nxt      = LOCKED;
                w_lock_owner_nxt = w_owner;
            end else begin
                w_state_nxt      = ROUND_ROBIN;
            end
        end
    end
`else
    assign w_arb_req0 = bus.req0;
    assign w_arb_req1 = bus.req1;
`endif

    dpram_arb_rr u_rr (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_req0 (w_arb_req0),
        .i_req1 (w_arb_req1),
        .o_gnt0 (w_rr_gnt0),
        .o_gnt1 (w_rr_gnt1)
    );

    assign w_gnt0   = w_rr_gnt0 & rst_n;
    assign w_gnt1   = w_rr_gnt1 & rst_n;
    assign bus.gnt0 = w_gnt0;
    assign bus.gnt1 = w_gnt1;

    assign w_xfer  = w_gnt0 | w_gnt1;
    assign w_owner = w_gnt1 ? c_OWNER1 : c_OWNER0;
    assign w_addr  = w_gnt1 ? bus.addr1  : bus.addr0;
    assign w_wdata = w_gnt1 ? bus.wdata1 : bus.wdata0;
    assign w_we    = w_gnt1 ? bus.we1    : bus.we0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr    <= '0;
            mem_wr_data <= '0;
            mem_wr_en   <= 1'b0;
        end else if (w_xfer) begin
            mem_addr    <= w_addr;
            mem_wr_data <= w_wdata;
            mem_wr_en   <= w_we;
        end else begin
            mem_wr_en   <= 1'b0;
        end
    end

    // Stage k holds a read accepted k edges ago; the last stage lines up with RAM data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ret <= '0;
        end else begin
            r_ret[0] <= '{valid: w_xfer & ~w_we, owner: w_owner};
            for (int i = 1; i <= RD_LATENCY; i++) begin
                r_ret[i] <= r_ret[i-1];
            end
        end
    end

    assign w_ret_out = r_ret[RD_LATENCY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
        end else begin
            r_rvalid0 <= w_ret_out.valid & (w_ret_out.owner == c_OWNER0);
            r_rvalid1 <= w_ret_out.valid & (w_ret_out.owner == c_OWNER1);
            if (w_ret_out.valid && (w_ret_out.owner == c_OWNER0)) begin
                r_rdata0 <= mem_rd_data;
            end
            if (w_ret_out.valid && (w_ret_out.owner == c_OWNER1)) begin
                r_rdata1 <= mem_rd_data;
            end
        end
    end

    assign bus.rvalid0 = r_rvalid0;
    assign bus.rvalid1 = r_rvalid1;
    assign bus.rdata0  = r_rdata0;
    assign bus.rdata1  = r_rdata1;

endmodule
`default_nettype wire

// File: tb/tb_dpram_port_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_dpram_port_arb
// Purpose  : Self-checking bench for dpram_port_arb with a behavioural RAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dpram_port_arb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  mem_addr;
    logic [15:0] mem_wr_data;
    logic        mem_wr_en;
    logic [15:0] mem_rd_data;

    dpram_port_arb_if #(.ADDR_WIDTH(10), .DATA_WIDTH(16)) bus ();

    dpram_port_arb #(.ADDR_WIDTH(10), .DATA_WIDTH(16), .RD_LATENCY(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .mem_wr_en   (mem_wr_en),
        .mem_rd_data (mem_rd_data)
    );

    always #5 clk = ~clk;

    // RAM port A: write-first, no output register.
    logic [15:0] ram [1024];
    always @(posedge clk) begin
        if (mem_wr_en) ram[mem_addr] <= mem_wr_data;
        mem_rd_data <= mem_wr_en ? mem_wr_data : ram[mem_addr];
    end

    typedef struct {
        bit          owner;
        logic [15:0] data;
        int          due;
    } exp_t;

    typedef struct {
        logic r0; logic w0; logic [9:0] a0; logic [15:0] d0;
        logic r1; logic w1; logic [9:0] a1; logic [15:0] d1;
        logic g0; logic g1;
    } vec_t;

    exp_t        sbq [$];
    logic [15:0] gold [1024];
    logic [9:0]  exp_addr = '0;
    logic [15:0] exp_wdata = '0;
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    int          cnt_rv0 = 0;
    int          cnt_rv1 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input longint act, input longint req);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, req, $time);
        end
    endtask

    // Read-return monitor against the scoreboard.
    always @(negedge clk) begin
        exp_t        e;
        logic [15:0] act_data;
        if (bus.rvalid0 || bus.rvalid1) begin
            if (bus.rvalid0) cnt_rv0++;
            if (bus.rvalid1) cnt_rv1++;
            check(!(bus.rvalid0 && bus.rvalid1), "rvalid_onehot", {bus.rvalid1, bus.rvalid0}, 1);
            check(sbq.size() > 0, "rvalid_expected", sbq.size(), 1);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                act_data = bus.rvalid1 ? bus.rdata1 : bus.rdata0;
                n_tests++;
                if (!(bus.rvalid1 == e.owner && act_data === e.data && cyc == e.due)) begin
                    n_fail++;
                    $display("FAIL rd_return: actual owner=%0d data=%h cycle=%0d, required owner=%0d data=%h cycle=%0d",
                             bus.rvalid1, act_data, cyc, e.owner, e.data, e.due);
                end
            end
        end else if (sbq.size() > 0 && sbq[0].due < cyc) begin
            n_tests++;
            n_fail++;
            $display("FAIL rd_missing: actual no rvalid by cycle %0d, required owner=%0d at cycle %0d",
                     cyc, sbq[0].owner, sbq[0].due);
            void'(sbq.pop_front());
        end
    end

    task automatic step(input logic r0, input logic w0, input logic [9:0] a0, input logic [15:0] d0,
                        input logic r1, input logic w1, input logic [9:0] a1, input logic [15:0] d1,
                        input logic eg0, input logic eg1);
        logic win, wo, ww;
        logic [9:0] wa;
        logic [15:0] wd;
        @(negedge clk);
        bus.req0 = r0; bus.we0 = w0; bus.addr0 = a0; bus.wdata0 = d0;
        bus.req1 = r1; bus.we1 = w1; bus.addr1 = a1; bus.wdata1 = d1;
        #1;
        check(bus.gnt0 === eg0, "gnt0", bus.gnt0, eg0);
        check(bus.gnt1 === eg1, "gnt1", bus.gnt1, eg1);
        win = (eg0 & r0) | (eg1 & r1);
        wo  = eg1 & r1;
        wa  = wo ? a1 : a0;
        wd  = wo ? d1 : d0;
        ww  = wo ? w1 : w0;
        if (win) begin
            exp_addr  = wa;
            exp_wdata = wd;
            if (ww) gold[wa] = wd;
            else    sbq.push_back('{owner: wo, data: gold[wa], due: cyc + 3});
        end
        @(posedge clk);
        #1;
        check(mem_wr_en === (win & ww), "mem_wr_en", mem_wr_en, win & ww);
        check(mem_addr === exp_addr, "mem_addr", mem_addr, exp_addr);
        check(mem_wr_data === exp_wdata, "mem_wr_data", mem_wr_data, exp_wdata);
    endtask

    task automatic idle_bus();
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual timeout, required completion");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        vec_t tbl [10];
        int   base;
        int   b0;

        idle_bus();
`ifdef DPRAM_ARB_LOCK_EN
        bus.lock0 = 1'b0;
        bus.lock1 = 1'b0;
`endif
        // Reset state, with requests pending to show grants are held off.
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        #12;
        check(bus.gnt0 === 1'b0, "rst_gnt0", bus.gnt0, 0);
        check(bus.gnt1 === 1'b0, "rst_gnt1", bus.gnt1, 0);
        check(mem_wr_en === 1'b0, "rst_mem_wr_en", mem_wr_en, 0);
        check(mem_addr === 10'd0, "rst_mem_addr", mem_addr, 0);
        check({bus.rvalid0, bus.rvalid1} === 2'b00, "rst_rvalid", {bus.rvalid0, bus.rvalid1}, 0);
        check({bus.rdata0, bus.rdata1} === 32'd0, "rst_rdata", {bus.rdata0, bus.rdata1}, 0);
        idle_bus();
        @(negedge clk);
        rst_n = 1'b1;

        // Fill the RAM from client 0, then read it all back from client 1.
        for (int i = 0; i < 1024; i++)
            step(1'b1, 1'b1, 10'(i), 16'(16'hFFFF - i), 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
        base = cnt_rv1;
        for (int i = 0; i < 1024; i++)
            step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 10'(i), '0, 1'b0, 1'b1);
        idle_bus();
        repeat (4) @(negedge clk);
        check(cnt_rv1 - base == 1024, "rv1_count", cnt_rv1 - base, 1024);

        // Write then read of the same address on consecutive edges.
        step(1'b1, 1'b1, 10'd5, 16'h1234, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 10'd5, '0, 1'b0, 1'b1);
        idle_bus();
        repeat (3) @(negedge clk);
        check(bus.rdata1 === 16'h1234, "raw_rdata1", bus.rdata1, 16'h1234);

        // Arbitration vectors; pointer currently names client 1.
        tbl[0] = '{1'b1, 1'b1, 10'd10, 16'hAAAA, 1'b1, 1'b1, 10'd11, 16'hBBBB, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 10'd10, 16'h0000, 1'b1, 1'b1, 10'd11, 16'hBBBB, 1'b0, 1'b1};
        tbl[2] = '{1'b1, 1'b0, 10'd10, 16'h0000, 1'b0, 1'b0, 10'd0,  16'h0000, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 10'd0,  16'h0000, 1'b1, 1'b0, 10'd11, 16'h0000, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 1'b0, 10'd0,  16'h0000, 1'b0, 1'b0, 10'd0,  16'h0000, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 10'd0,  16'h0000, 1'b1, 1'b0, 10'd10, 16'h0000, 1'b0, 1'b1};
        tbl[6] = '{1'b1, 1'b0, 10'd11, 16'h0000, 1'b1, 1'b0, 10'd11, 16'h0000, 1'b1, 1'b0};
        tbl[7] = '{1'b1, 1'b0, 10'd11, 16'h0000, 1'b1, 1'b0, 10'd11, 16'h0000, 1'b0, 1'b1};
        tbl[8] = '{1'b1, 1'b1, 10'd10, 16'h5555, 1'b1, 1'b0, 10'd10, 16'h0000, 1'b1, 1'b0};
        tbl[9] = '{1'b0, 1'b0, 10'd0,  16'h0000, 1'b1, 1'b0, 10'd10, 16'h0000, 1'b0, 1'b1};
        for (int i = 0; i < 10; i++)
            step(tbl[i].r0, tbl[i].w0, tbl[i].a0, tbl[i].d0,
                 tbl[i].r1, tbl[i].w1, tbl[i].a1, tbl[i].d1, tbl[i].g0, tbl[i].g1);

        // Idle: no write strobes, address holds.
        for (int i = 0; i < 10; i++)
            step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);

        // Reset with two reads in flight.
        step(1'b1, 1'b0, 10'd100, '0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 10'd200, '0, 1'b0, 1'b1);
        rst_n = 1'b0;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        #1;
        sbq.delete();
        exp_addr = '0;
        exp_wdata = '0;
        check(bus.gnt0 === 1'b0, "midrst_gnt0", bus.gnt0, 0);
        check(bus.gnt1 === 1'b0, "midrst_gnt1", bus.gnt1, 0);
        check(mem_wr_en === 1'b0, "midrst_mem_wr_en", mem_wr_en, 0);
        check(mem_addr === 10'd0, "midrst_mem_addr", mem_addr, 0);
        check(mem_wr_data === 16'd0, "midrst_mem_wr_data", mem_wr_data, 0);
        check({bus.rvalid0, bus.rvalid1} === 2'b00, "midrst_rvalid", {bus.rvalid0, bus.rvalid1}, 0);
        check(bus.rdata0 === 16'd0, "midrst_rdata0", bus.rdata0, 0);
        check(bus.rdata1 === 16'd0, "midrst_rdata1", bus.rdata1, 0);
        base = cnt_rv0 + cnt_rv1;
        repeat (4) @(negedge clk);
        check(cnt_rv0 + cnt_rv1 == base, "midrst_no_rvalid", cnt_rv0 + cnt_rv1 - base, 0);
        idle_bus();
        rst_n = 1'b1;

        // Both clients reading continuously: 0,1,0,1,... starting with 0.
        b0 = cnt_rv0;
        base = cnt_rv1;
        for (int i = 0; i < 8; i++)
            step(1'b1, 1'b0, 10'(300 + i), '0, 1'b1, 1'b0, 10'(400 + i), '0,
                 (i % 2) == 0, (i % 2) == 1);
        idle_bus();
        repeat (4) @(negedge clk);
        check(cnt_rv0 - b0 == 4, "alt_rv0_count", cnt_rv0 - b0, 4);
        check(cnt_rv1 - base == 4, "alt_rv1_count", cnt_rv1 - base, 4);

`ifdef DPRAM_ARB_LOCK_EN
        // Client 1 burst-locks: four locked transfers, one unlocking, then client 0.
        bus.lock1 = 1'b1;
        step(1'b1, 1'b0, 10'd20, '0, 1'b1, 1'b0, 10'd21, '0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 10'd20, '0, 1'b1, 1'b0, 10'd21, '0, 1'b0, 1'b1);
        bus.lock0 = 1'b1;
        step(1'b1, 1'b0, 10'd20, '0, 1'b1, 1'b0, 10'd22, '0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 10'd20, '0, 1'b1, 1'b0, 10'd23, '0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 10'd20, '0, 1'b0, 1'b0, '0,     '0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 10'd20, '0, 1'b1, 1'b0, 10'd24, '0, 1'b0, 1'b1);
        bus.lock0 = 1'b0;
        bus.lock1 = 1'b0;
        step(1'b1, 1'b0, 10'd20, '0, 1'b1, 1'b0, 10'd25, '0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 10'd20, '0, 1'b1, 1'b0, 10'd26, '0, 1'b1, 1'b0);
        idle_bus();
`endif

        repeat (6) @(negedge clk);
        check(sbq.size() == 0, "sb_drain", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dpram_port_arb.md
# dpram_port_arb

Two-requester arbiter that shares a single port of the `dpram` block (port A, 1024 x 16, no output register) between two clients. It accepts at most one read or write per clock, grants round-robin, and drives registered address, data and write enable into the RAM. It returns read data to the client that issued the read, tagged with a one-cycle valid. It sits between the RAM and its two clients, for example a capture writer and a processing reader.

## Interface
- `ADDR_WIDTH`, default 10: RAM address width.
- `DATA_WIDTH`, default 16: RAM data width.
- `RD_LATENCY`, default 1: RAM clock edges from address sample to data valid. Use 1 without an output register, 2 with one. Legal range 1..3.
- `clk`  in  1: single clock, also drives the RAM port clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req0` / `req1`  in  1: access request, held until granted.
- `we0` / `we1`  in  1: 1 = write, 0 = read. Qualified by req.
- `addr0` / `addr1`  in  ADDR_WIDTH: access address.
- `wdata0` / `wdata1`  in  DATA_WIDTH: write data.
- `gnt0` / `gnt1`  out  1: combinational grant. Transfer occurs on the edge where req and gnt are both 1.
- `rvalid0` / `rvalid1`  out  1: one-cycle read-return strobe.
- `rdata0` / `rdata1`  out  DATA_WIDTH: registered read data, valid when rvalid is 1.
- `mem_addr`  out  ADDR_WIDTH: to RAM address.
- `mem_wr_data`  out  DATA_WIDTH: to RAM write data.
- `mem_wr_en`  out  1: to RAM write enable.
- `mem_rd_data`  in  DATA_WIDTH: from RAM read data.
- `lock0` / `lock1`  in  1: burst lock. Present only with `DPRAM_ARB_LOCK_EN`.

## Operation
- Arbitration state is a round-robin pointer `last` (0 or 1), the requester granted most recently.
  - Only one req: that requester is granted.
  - Both req: the requester other than `last` is granted.
  - `last` updates on every transfer.
- At most one gnt is high per cycle. gnt is low when its req is low.
- On a transfer, the issue stage registers addr, wdata, we and owner id into the `mem_*` outputs for exactly one cycle.
- In cycles with no transfer, `mem_wr_en` = 0 and `mem_addr` / `mem_wr_data` hold their last values.
- Reads push {valid, owner} into a return pipeline of RD_LATENCY+1 stages. The last stage captures `mem_rd_data` into `rdata<owner>` and pulses `rvalid<owner>`.
- Reads are fully pipelined: back-to-back reads from either or both clients are supported, one per cycle.
- Writes produce no response.
- A non-owner's rdata holds its previous value.
- Same-address write then read, back to back: the read returns the newly written data. The RAM port is transparent, and the arbiter adds no hazard logic.
- Reset, including assertion mid-operation:
  - gnt0/1 = 0 while rst_n = 0.
  - `mem_wr_en` = 0, `mem_addr` = 0, `mem_wr_data` = 0.
  - rvalid0/1 = 0, rdata0/1 = 0.
  - `last` = 1, so requester 0 wins the first contention.
  - Return pipeline cleared: in-flight reads are dropped and never strobe.

## Timing
- gnt is combinational from req, `last` and the lock state, in the same cycle.
- Transfer at edge N: `mem_*` valid from N to N+1. The RAM samples at N+1.
- Read return: rvalid is high for the single cycle after edge N+1+RD_LATENCY. With the default, a read accepted at edge N has rvalid high after edge N+2.
- Write: the RAM is updated at edge N+1.
- Throughput: one transfer per cycle. With both clients requesting continuously, grants alternate 0,1,0,1.

## Configuration
- `DPRAM_ARB_LOCK_EN` defined:
  - lock0/lock1 ports exist.
  - If the current owner's lock is high at its transfer edge, the arbiter enters a LOCKED state for that owner. In LOCKED, only that owner can be granted, even if idle, until it makes a transfer with lock low. That final transfer returns the arbiter to ROUND_ROBIN.
  - Reset returns to ROUND_ROBIN.
  - A lock request from the other requester while LOCKED is ignored.
- Undefined: no lock ports and no LOCKED state. Pure round-robin.

## Structure
- Package `dpram_arb_pkg` holds:
  - owner id type (1 bit);
  - the arbiter state enum (ROUND_ROBIN, LOCKED);
  - the return-pipeline stage struct {valid, owner}.
- Sub-module `dpram_arb_rr`: combinational two-way round-robin grant plus the `last` pointer register. The top module holds the issue stage, the return pipeline and the lock FSM.

## Test plan
- Write from client 0 only, at addresses 0..1023 with data 16'hFFFF counting down. Then read back from client 1 → 1024 rvalid1 pulses with matching data, each 2 cycles after its grant.
- req0 and req1 held high for 8 cycles, both reading → gnt sequence 0,1,0,1,… and 4 rvalid pulses per client. The first grant goes to 0 after reset.
- Client 0 writes 16'h1234 to address 5 at edge N, then client 1 reads address 5 at edge N+1 → rdata1 = 16'h1234.
- rst_n pulled low with 2 reads in flight → no rvalid, and all outputs return to 0 asynchronously. First access after release goes to client 0.
- Idle: no req for 10 cycles → mem_wr_en = 0 throughout and mem_addr held.
- With `DPRAM_ARB_LOCK_EN`: client 1 holds lock for 4 transfers with req0 high continuously → 4 consecutive gnt1, then 5th transfer (lock1 low) also goes to client 1, then gnt0.
